// File: rtl/hub75_receiver_if.sv
// HUB75 receiver bus: panel-side input lines plus decoded pixel outputs.
// master drives the panel lines, slave is the receiver.
interface hub75_receiver_if #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int segments_p = 2,
  parameter int bpp_p      = 8
);
  localparam int addr_w  = $clog2(hpixel_p * vpixel_p);
  localparam int plane_w = $clog2(bpp_p);
  localparam int rgb_w   = segments_p * 3;

  logic               i_enable;
  logic               i_hub_clk;
  logic               i_stb;
  logic               i_oe;
  logic [4:0]         i_row;
  logic               i_r1;
  logic               i_g1;
  logic               i_b1;
  logic               i_r2;
  logic               i_g2;
  logic               i_b2;
  logic               o_px_valid;
  logic [addr_w-1:0]  o_px_addr;
  logic [plane_w-1:0] o_px_plane;
  logic [rgb_w-1:0]   o_px_rgb;
  logic               o_err_short;
  logic               o_err_busy;

  modport master (
    output i_enable, i_hub_clk, i_stb, i_oe, i_row,
    output i_r1, i_g1, i_b1, i_r2, i_g2, i_b2,
    input  o_px_valid, o_px_addr, o_px_plane, o_px_rgb,
    input  o_err_short, o_err_busy
  );

  modport slave (
    input  i_enable, i_hub_clk, i_stb, i_oe, i_row,
    input  i_r1, i_g1, i_b1, i_r2, i_g2, i_b2,
    output o_px_valid, o_px_addr, o_px_plane, o_px_rgb,
    output o_err_short, o_err_busy
  );
endinterface

// File: rtl/hub75_receiver.sv
// HUB75 panel receiver: captures shifted columns, latches rows on strobe,
// and replays each latched row as a stream of decoded pixels.
module hub75_receiver #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int segments_p = 2,
  parameter int bpp_p      = 8
) (
  input  logic            clk,
  input  logic            rst,
  hub75_receiver_if.slave bus
);
  localparam int rows_p  = vpixel_p / segments_p;
  localparam int row_w   = $clog2(rows_p);
  localparam int addr_w  = $clog2(hpixel_p * vpixel_p);
  localparam int plane_w = $clog2(bpp_p);
  localparam int col_w   = $clog2(hpixel_p + 1);
  localparam int ocol_w  = $clog2(hpixel_p);
  localparam int rgb_w   = segments_p * 3;

  typedef enum logic {IDLE, STREAM} state_t;

  // {oe, stb, hclk, row[4:0], r2, g2, b2, r1, g1, b1}
  logic [13:0]        raw;
  logic [13:0]        sync1_q, sync2_q;
  logic               hclk_h_q, stb_h_q;
  logic               hub_rise_q, stb_rise_q;
  logic [5:0]         dat_q;
  logic [row_w-1:0]   row_q;
  logic [rgb_w-1:0]   col_rgb;

  logic [rgb_w-1:0]   cap_q [hpixel_p];
  logic [rgb_w-1:0]   out_q [hpixel_p];

  state_t             state_q, state_d;
  logic [col_w-1:0]   col_q, col_d, col_upd;
  logic [ocol_w-1:0]  ocol_q, ocol_d;
  logic [plane_w-1:0] plane_q, plane_d;
  logic [row_w-1:0]   last_row_q, orow_q;
  logic               last_vld_q;
  logic               col_inc, busy, short_e, accept;

  logic               px_valid_q, err_short_q, err_busy_q;
  logic [addr_w-1:0]  addr_q, px_addr;
  logic [plane_w-1:0] oplane_q;
  logic [rgb_w-1:0]   rgb_q;
  logic               unused_q;

  assign raw = {bus.i_oe, bus.i_stb, bus.i_hub_clk, bus.i_row,
                bus.i_r2, bus.i_g2, bus.i_b2,
                bus.i_r1, bus.i_g1, bus.i_b1};

  // oe is synchronized for completeness but never decoded
  assign unused_q = ^{sync2_q[13], sync2_q[10:6]};

  // two-flop synchronizer, then registered edge pulses aligned with data
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      hclk_h_q   <= 1'b0;
      stb_h_q    <= 1'b0;
      hub_rise_q <= 1'b0;
      stb_rise_q <= 1'b0;
      dat_q      <= '0;
      row_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      hclk_h_q   <= sync2_q[11];
      stb_h_q    <= sync2_q[12];
      hub_rise_q <= bus.i_enable & sync2_q[11] & ~hclk_h_q;
      stb_rise_q <= bus.i_enable & sync2_q[12] & ~stb_h_q;
      dat_q      <= sync2_q[5:0];
      row_q      <= sync2_q[6 +: row_w];
    end
  end

  // map the two physical segments onto the packed rgb word
  always_comb begin
    col_rgb = '0;
    for (int s = 0; s < segments_p && s < 2; s++)
      col_rgb[s*3 +: 3] = dat_q[s*3 +: 3];
  end

  // column capture first, strobe judged on the updated count
  always_comb begin
    col_inc = hub_rise_q && (col_q != col_w'(hpixel_p));
    col_upd = col_q + col_w'(col_inc);
    busy    = stb_rise_q && (state_q == STREAM);
    short_e = stb_rise_q && !busy &&
              (col_upd != col_w'(hpixel_p));
    accept  = stb_rise_q && !busy && !short_e;
    col_d   = stb_rise_q ? '0 : col_upd;
    plane_d = plane_q;
    if (accept) begin
      if (last_vld_q && row_q == last_row_q &&
          plane_q != plane_w'(bpp_p - 1))
        plane_d = plane_q + 1'b1;
      else
        plane_d = '0;
    end
    state_d = state_q;
    ocol_d  = ocol_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          ocol_d  = '0;
        end
      end
      STREAM: begin
        ocol_d = ocol_q + 1'b1;
        if (ocol_q == ocol_w'(hpixel_p - 1)) begin
          state_d = IDLE;
          ocol_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      ocol_q     <= '0;
      plane_q    <= '0;
      last_row_q <= '0;
      last_vld_q <= 1'b0;
      orow_q     <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ocol_q  <= ocol_d;
      plane_q <= plane_d;
      if (accept) begin
        last_row_q <= row_q;
        last_vld_q <= 1'b1;
        orow_q     <= row_q;
      end
    end
  end

  // capture buffer fills freely; output buffer only on accepted latch
  always_ff @(posedge clk) begin
    if (!rst && col_inc)
      cap_q[col_q[ocol_w-1:0]] <= col_rgb;
    if (!rst && accept)
      for (int i = 0; i < hpixel_p; i++)
        out_q[i] <= (col_inc && col_q == col_w'(i)) ?
                    col_rgb : cap_q[i];
  end

  assign px_addr = addr_w'(orow_q) * addr_w'(hpixel_p) +
                   addr_w'(ocol_q);

  // registered pixel outputs, held between streams
  always_ff @(posedge clk) begin
    if (rst) begin
      px_valid_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_busy_q  <= 1'b0;
      addr_q      <= '0;
      oplane_q    <= '0;
      rgb_q       <= '0;
    end else begin
      px_valid_q  <= (state_q == STREAM);
      err_short_q <= short_e;
      err_busy_q  <= busy;
      if (state_q == STREAM) begin
        addr_q   <= px_addr;
        oplane_q <= plane_q;
        rgb_q    <= out_q[ocol_q];
      end
    end
  end

  assign bus.o_px_valid  = px_valid_q;
  assign bus.o_px_addr   = addr_q;
  assign bus.o_px_plane  = oplane_q;
  assign bus.o_px_rgb    = rgb_q;
  assign bus.o_err_short = err_short_q;
  assign bus.o_err_busy  = err_busy_q;
endmodule

// File: tb/tb_hub75_receiver.sv
// Scoreboard bench for hub75_receiver: rows pushed as expected pixels,
// monitor pops and compares on every o_px_valid cycle.
module tb_hub75_receiver;
  localparam int H = 64;
  localparam int V = 64;
  localparam int S = 2;
  localparam int B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hub75_receiver_if #(
    .hpixel_p(H), .vpixel_p(V),
    .segments_p(S), .bpp_p(B)
  ) bus ();

  hub75_receiver #(
    .hpixel_p(H), .vpixel_p(V),
    .segments_p(S), .bpp_p(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int addr;
    int plane;
    int rgb;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_short = 0;
  int n_busy = 0;
  int m_last = -1;
  int m_plane = 0;
  int stb_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // monitor: compare every presented pixel against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_err_short) n_short++;
      if (bus.o_err_busy) n_busy++;
      if (bus.o_px_valid) begin
        n_valid++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: addr %0d, expected none",
                   bus.o_px_addr);
        end else begin
          me = q.pop_front();
          chk("px_addr", int'(bus.o_px_addr), me.addr);
          chk("px_plane", int'(bus.o_px_plane), me.plane);
          chk("px_rgb", int'(bus.o_px_rgb), me.rgb);
          if (me.cyc >= 0) chk("latency", cyc, me.cyc);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // {r2,g2,b2,r1,g1,b1} for column c
  function automatic logic [5:0] px(int c, int pat);
    logic [5:0] v;
    v = '0;
    if (pat == 0) begin
      v[2] = c[0];
      v[4] = 1'b1;
    end else begin
      v[1] = c[0];
      v[0] = c[1];
      v[5] = c[2];
      v[3] = c[3];
    end
    return v;
  endfunction

  task automatic set_data(logic [5:0] v);
    {bus.i_r2, bus.i_g2, bus.i_b2,
     bus.i_r1, bus.i_g1, bus.i_b1} = v;
  endtask

  task automatic strobe(int row, int pat, bit acc);
    int p;
    exp_t e;
    bus.i_row = 5'(row);
    bus.i_stb = 1'b1;
    stb_cyc = cyc;
    if (acc) begin
      p = (m_last == row) ? (m_plane + 1) % B : 0;
      m_last = row;
      m_plane = p;
      for (int c = 0; c < H; c++) begin
        e.addr = row * H + c;
        e.plane = p;
        e.rgb = int'(px(c, pat));
        e.cyc = (c == 0) ? stb_cyc + 5 : -1;
        q.push_back(e);
      end
    end
    tick(3);
    bus.i_stb = 1'b0;
    bus.i_hub_clk = 1'b0;
    tick(2);
  endtask

  task automatic send_row(int row, int ncols, int pat,
                          bit same, bit acc);
    for (int c = 0; c < ncols; c++) begin
      set_data(px(c, pat));
      bus.i_hub_clk = 1'b0;
      tick(2);
      bus.i_hub_clk = 1'b1;
      if (!(same && c == ncols - 1)) tick(2);
    end
    if (!same) bus.i_hub_clk = 1'b0;
    strobe(row, pat, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      tick(1);
      n++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d pixels left, expected 0", q.size());
    end
    tick(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nv;
    int ns;
    int nb;
    bit hit;
    bus.i_enable = 1'b1;
    bus.i_hub_clk = 1'b0;
    bus.i_stb = 1'b0;
    bus.i_oe = 1'b1;
    bus.i_row = '0;
    set_data('0);
    tick(4);
    chk("rst_valid", int'(bus.o_px_valid), 0);
    chk("rst_addr", int'(bus.o_px_addr), 0);
    chk("rst_plane", int'(bus.o_px_plane), 0);
    chk("rst_rgb", int'(bus.o_px_rgb), 0);
    chk("rst_short", int'(bus.o_err_short), 0);
    chk("rst_busy", int'(bus.o_err_busy), 0);
    rst = 1'b0;
    tick(3);

    // row 3 repeated: planes 0..7 then wrap, then row 4, then row 3
    send_row(3, H, 0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) send_row(3, H, 1, 1'b0, 1'b1);
    send_row(3, H, 0, 1'b0, 1'b1);
    send_row(4, H, 1, 1'b0, 1'b1);
    send_row(3, H, 0, 1'b0, 1'b1);
    drain();
    chk("no_short_yet", n_short, 0);
    chk("no_busy_yet", n_busy, 0);

    // short row then a normal one
    nv = n_valid;
    send_row(7, H - 1, 0, 1'b0, 1'b0);
    tick(20);
    chk("short_pulse", n_short, 1);
    chk("short_no_valid", n_valid, nv);
    send_row(7, H, 1, 1'b0, 1'b1);
    drain();

    // strobe ten cycles into a stream
    send_row(9, H, 1, 1'b0, 1'b1);
    base = stb_cyc + 14;
    while (cyc < base) tick(1);
    strobe(9, 0, 1'b0);
    drain();
    chk("busy_pulse", n_busy, 1);
    chk("busy_no_short", n_short, 1);

    // strobe together with the last shift edge
    send_row(10, H, 0, 1'b1, 1'b1);
    drain();

    // disabled capture is ignored entirely
    nv = n_valid;
    ns = n_short;
    nb = n_busy;
    bus.i_enable = 1'b0;
    send_row(11, H, 0, 1'b0, 1'b0);
    tick(80);
    chk("dis_valid", n_valid, nv);
    chk("dis_short", n_short, ns);
    chk("dis_busy", n_busy, nb);
    bus.i_enable = 1'b1;
    tick(2);
    send_row(11, H, 1, 1'b0, 1'b1);
    drain();

    // reset in the middle of a stream
    send_row(12, H, 0, 1'b0, 1'b1);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      tick(1);
      if (bus.o_px_valid && int'(bus.o_px_addr) == 12 * H + 20)
        hit = 1'b1;
    end
    chk("col20_seen", int'(hit), 1);
    rst = 1'b1;
    tick(1);
    chk("abort_valid", int'(bus.o_px_valid), 0);
    chk("abort_addr", int'(bus.o_px_addr), 0);
    chk("abort_rgb", int'(bus.o_px_rgb), 0);
    tick(3);
    q.delete();
    m_last = -1;
    m_plane = 0;
    rst = 1'b0;
    tick(3);
    nv = n_valid;
    tick(100);
    chk("abort_no_valid", n_valid, nv);
    send_row(12, H, 1, 1'b0, 1'b1);
    drain();

    chk("short_total", n_short, 1);
    chk("busy_total", n_busy, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
